mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the CPU's single unified memory port between instruction fetch (IF) and data load/store (DM). It accepts one request at a time, fixed priority DM > IF, and sequences the memory handshake (request, grant, response). It routes the response back to the requester that owns the transaction. It sits between the fetch/load-store logic driven by the control unit and the external memory.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8
TIMEOUT_CYCLES, 255, abort threshold in cycles; used only with the optional feature

Ports:
clk  input  1  clock
rst_n  input  1  reset
if_req  input  1  fetch request; held stable until if_gnt
if_addr  input  ADDR_WIDTH  fetch address
if_gnt  output  1  fetch request accepted (1-cycle pulse)
if_rvalid  output  1  fetch response valid (1-cycle pulse)
if_rdata  output  DATA_WIDTH  fetch response data
dm_req  input  1  data request; held stable until dm_gnt
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  DATA_WIDTH  store data
dm_wstrb  input  DATA_WIDTH/8  store byte enables
dm_gnt  output  1  data request accepted (1-cycle pulse)
dm_rvalid  output  1  data response or store ack (1-cycle pulse)
dm_rdata  output  DATA_WIDTH  load data
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_wstrb  output  DATA_WIDTH/8  memory byte enables
mem_gnt  input  1  memory accepted request
mem_rvalid  input  1  memory response valid (reads and writes)
mem_rdata  input  DATA_WIDTH  memory read data
busy  output  1  transaction in flight (state != ARB_IDLE)
bus_err  output  1  transaction aborted by timeout (1-cycle pulse)

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- During reset and after reset: state ARB_IDLE; every output is 0, including if_gnt and dm_gnt, which are forced to 0 while rst_n = 0.
- FSM ARB_IDLE:
  - If dm_req: dm_gnt = 1 (combinational, same cycle). Capture dm_we, dm_addr, dm_wdata, and dm_wstrb masked to 0 when dm_we = 0. Owner = DM. Next state ARB_ADDR.
  - Else if if_req: if_gnt = 1. Capture if_addr, with we = 0, wdata = 0, wstrb = 0. Owner = IF. Next state ARB_ADDR.
  - Else stay in ARB_IDLE.
- FSM ARB_ADDR:
  - mem_req = 1; mem_* driven from the captured registers.
  - On mem_gnt, go to ARB_RESP. mem_req drops in the following cycle.
- FSM ARB_RESP:
  - mem_req = 0.
  - On mem_rvalid: owner's rvalid = 1 and owner's rdata = mem_rdata, both combinational in the same cycle. Next state ARB_IDLE.
- Requests are never accepted outside ARB_IDLE. Minimum transaction is 3 cycles: accept, address with mem_gnt, response.
- Non-owner rvalid is 0. Non-owner rdata is 0. Owner rdata is 0 except in its rvalid cycle.
- mem_rvalid in ARB_IDLE or ARB_ADDR is ignored. mem_gnt outside ARB_ADDR is ignored.
- The captured registers are held until return to ARB_IDLE. A requester may change its inputs after its gnt.
- Simultaneous if_req and dm_req: DM is served first. IF is served in the first ARB_IDLE cycle after DM completes, provided if_req is still high.
- Reset mid-operation: the next cycle is ARB_IDLE with mem_req = 0. A late mem_rvalid is ignored and no requester rvalid is produced.
- bus_err = 0 always, unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With it defined:
  - A counter clears on leaving ARB_IDLE and increments every cycle in ARB_ADDR and ARB_RESP.
  - When the count equals TIMEOUT_CYCLES-1 and the current state's handshake (mem_gnt in ARB_ADDR, mem_rvalid in ARB_RESP) is absent that cycle, the transaction aborts:
    - owner rvalid = 1 with rdata = ERR_RDATA (32'hDEAD_BEEF);
    - bus_err = 1;
    - mem_req deasserts;
    - next state ARB_IDLE.
  - A handshake arriving in the abort cycle takes precedence, and no abort occurs.
- Without it: the counter is absent, the FSM waits indefinitely, and bus_err is tied to 0.

Decomposition:
- Package mem_arb_pkg contains:
  - typedef enum state_t {ARB_IDLE, ARB_ADDR, ARB_RESP};
  - typedef enum owner_t {OWN_IF, OWN_DM};
  - localparam ERR_RDATA.
- One natural sub-module, mem_timeout_ctr: clear, enable, and terminal-count output. It is instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- IF only: if_req with if_addr = 0x0000_0010. Memory gives mem_gnt on the 2nd ARB_ADDR cycle and mem_rvalid 2 cycles later with rdata = 0x0050_0093.
  -> if_gnt pulses in cycle 0; mem_req is high for 2 cycles with mem_addr = 0x10 and mem_wstrb = 0; if_rvalid = 1 with if_rdata = 0x0050_0093; dm_rvalid stays 0.
- Simultaneous requests: if_req (0x20) and a DM store (0x100, 0xCAFE_BABE, wstrb 0xF).
  -> dm_gnt first; mem_we = 1 with the store fields; dm_rvalid on ack; then if_gnt and an IF read. Each gnt and each rvalid occurs exactly once.
- DM load with dm_wstrb = 0x3 and dm_we = 0 -> mem_wstrb = 0 and mem_we = 0; dm_rdata = mem_rdata in the rvalid cycle.
- Spurious mem_rvalid in ARB_IDLE and in ARB_ADDR -> no requester rvalid; FSM unaffected.
- rst_n low for 1 cycle while in ARB_RESP -> next cycle ARB_IDLE with busy = 0 and mem_req = 0; a subsequent mem_rvalid yields no rvalid.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and a memory that grants but never responds:
  -> in the 8th cycle after leaving ARB_IDLE, owner rvalid = 1, rdata = 0xDEAD_BEEF, bus_err = 1, then ARB_IDLE.
  -> Without the macro: busy stays 1 and bus_err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Desc     : Shared types and constants for the unified memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Read data returned to the owner when a transaction is aborted.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_ctr
// Desc     : Cycle counter with clear/enable; tc flags count == TIMEOUT_CYCLES-1.
// Revision : 1.0
// ============================================================================
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_terminal)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = en && (r_cnt == c_terminal);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Desc     : Shares one memory port between fetch (IF) and data (DM), DM first.
//            Define MEM_ARB_TIMEOUT_EN to abort stalled transactions.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    bus_err
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  owner_t                  r_owner;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;

  logic w_idle, w_in_addr, w_in_resp;
  logic w_dm_accept, w_if_accept;
  logic w_done, w_abort, w_finish;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_idle      = (r_state == ARB_IDLE);
  assign w_in_addr   = (r_state == ARB_ADDR);
  assign w_in_resp   = (r_state == ARB_RESP);
  assign w_dm_accept = w_idle && dm_req;
  assign w_if_accept = w_idle && if_req && !dm_req;
  assign w_done      = w_in_resp && mem_rvalid;
  assign w_finish    = w_done || w_abort;

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_tc;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_dm_accept || w_if_accept),
    .en    (!w_idle),
    .tc    (w_tc)
  );

  // A handshake in the terminal cycle wins over the abort.
  assign w_abort = w_tc && ((w_in_addr && !mem_gnt) || (w_in_resp && !mem_rvalid));
  assign w_rdata = w_abort ? DATA_WIDTH'(ERR_RDATA) : mem_rdata;
  assign bus_err = rst_n && w_abort;
`else
  assign w_abort = 1'b0;
  assign w_rdata = mem_rdata;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_dm_accept || w_if_accept) w_state_nxt = ARB_ADDR;
      ARB_ADDR: begin
        if (mem_gnt)      w_state_nxt = ARB_RESP;
        else if (w_abort) w_state_nxt = ARB_IDLE;
      end
      ARB_RESP: if (w_finish) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dm_accept) begin
        r_owner <= OWN_DM;
        r_we    <= dm_we;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
        r_wstrb <= dm_we ? dm_wstrb : '0;
      end else if (w_if_accept) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
        r_wstrb <= '0;
      end
    end
  end

  // Outputs are gated by rst_n so everything reads 0 during the reset cycle.
  assign dm_gnt    = rst_n && w_dm_accept;
  assign if_gnt    = rst_n && w_if_accept;
  assign busy      = rst_n && !w_idle;
  assign mem_req   = rst_n && w_in_addr && !w_abort;
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;
  assign mem_wstrb = mem_req ? r_wstrb : '0;

  assign if_rvalid = rst_n && w_finish && (r_owner == OWN_IF);
  assign dm_rvalid = rst_n && w_finish && (r_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? w_rdata : '0;
  assign dm_rdata  = dm_rvalid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Desc     : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, bus_err;

  int checks   = 0;
  int failures = 0;
  int n_if_gnt = 0, n_dm_gnt = 0, n_if_rv = 0, n_dm_rv = 0;
  int s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv;

  mem_port_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_wstrb   (dm_wstrb),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin
    if (if_gnt)    n_if_gnt++;
    if (dm_gnt)    n_dm_gnt++;
    if (if_rvalid) n_if_rv++;
    if (dm_rvalid) n_dm_rv++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n  = 0;
    if_req = 1; if_addr = 32'h44;
    dm_req = 1; dm_addr = 32'h88;

    // Reset: grants suppressed even with requests present
    tick(); tick(); settle();
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    clear_inputs();
    tick(); rst_n = 1;

    // IF only: gnt in 2nd ADDR cycle, rvalid 2 cycles later
    tick(); if_req = 1; if_addr = 32'h10; settle();
    check("if_gnt", {31'd0, if_gnt}, 32'd1);
    check("if_idle_busy", {31'd0, busy}, 32'd0);
    tick(); if_req = 0; if_addr = 32'hFFFF_FFFF; settle();
    check("if_mreq1", {31'd0, mem_req}, 32'd1);
    check("if_maddr", mem_addr, 32'h10);
    check("if_mwstrb", {28'd0, mem_wstrb}, 32'd0);
    check("if_busy", {31'd0, busy}, 32'd1);
    tick(); mem_gnt = 1; settle();
    check("if_mreq2", {31'd0, mem_req}, 32'd1);
    tick(); mem_gnt = 0; settle();
    check("if_mreq_drop", {31'd0, mem_req}, 32'd0);
    check("if_rv_early", {31'd0, if_rvalid}, 32'd0);
    tick(); mem_rvalid = 1; mem_rdata = 32'h0050_0093; settle();
    check("if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("if_rdata", if_rdata, 32'h0050_0093);
    check("if_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    check("if_dm_rdata", dm_rdata, 32'd0);
    tick(); clear_inputs(); settle();
    check("if_back_idle", {31'd0, busy}, 32'd0);
    check("if_rdata_zero", if_rdata, 32'd0);

    // Simultaneous requests: DM store first, then IF read
    s_if_gnt = n_if_gnt; s_dm_gnt = n_dm_gnt; s_if_rv = n_if_rv; s_dm_rv = n_dm_rv;
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hCAFE_BABE; dm_wstrb = 4'hF;
    settle();
    check("sim_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    check("sim_if_gnt0", {31'd0, if_gnt}, 32'd0);
    tick(); dm_req = 0; dm_we = 0; dm_wdata = '0; dm_wstrb = '0; mem_gnt = 1; settle();
    check("sim_mem_we", {31'd0, mem_we}, 32'd1);
    check("sim_maddr", mem_addr, 32'h100);
    check("sim_mwdata", mem_wdata, 32'hCAFE_BABE);
    check("sim_mwstrb", {28'd0, mem_wstrb}, 32'hF);
    check("sim_if_gnt_busy", {31'd0, if_gnt}, 32'd0);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0; settle();
    check("sim_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    check("sim_if_rv0", {31'd0, if_rvalid}, 32'd0);
    tick(); mem_rvalid = 0; settle();
    check("sim_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); if_req = 0; mem_gnt = 1; settle();
    check("sim_if_maddr", mem_addr, 32'h20);
    check("sim_if_mwe", {31'd0, mem_we}, 32'd0);
    check("sim_if_mwdata", mem_wdata, 32'd0);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; settle();
    check("sim_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("sim_if_rdata", if_rdata, 32'h1234_5678);
    check("sim_dm_rv0", {31'd0, dm_rvalid}, 32'd0);
    tick(); clear_inputs();
    check("sim_n_dm_gnt", n_dm_gnt - s_dm_gnt, 32'd1);
    check("sim_n_if_gnt", n_if_gnt - s_if_gnt, 32'd1);
    check("sim_n_dm_rv",  n_dm_rv  - s_dm_rv,  32'd1);
    check("sim_n_if_rv",  n_if_rv  - s_if_rv,  32'd1);

    // DM load with nonzero strobes: strobes masked to 0
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; dm_wstrb = 4'h3; settle();
    check("ld_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    tick(); dm_req = 0; mem_gnt = 1; settle();
    check("ld_mwstrb", {28'd0, mem_wstrb}, 32'd0);
    check("ld_mwe", {31'd0, mem_we}, 32'd0);
    check("ld_maddr", mem_addr, 32'h200);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001; settle();
    check("ld_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    check("ld_dm_rdata", dm_rdata, 32'hA5A5_0001);
    check("ld_if_rdata", if_rdata, 32'd0);
    tick(); clear_inputs();

    // Spurious mem_rvalid in IDLE and ADDR
    mem_rvalid = 1; mem_rdata = 32'h77; settle();
    check("sp_idle_ifrv", {31'd0, if_rvalid}, 32'd0);
    check("sp_idle_dmrv", {31'd0, dm_rvalid}, 32'd0);
    check("sp_idle_busy", {31'd0, busy}, 32'd0);
    if_req = 1; if_addr = 32'h30; settle();
    check("sp_if_gnt", {31'd0, if_gnt}, 32'd1);
    check("sp_gnt_ifrv", {31'd0, if_rvalid}, 32'd0);
    tick(); if_req = 0; settle();
    check("sp_addr_ifrv", {31'd0, if_rvalid}, 32'd0);
    check("sp_addr_mreq", {31'd0, mem_req}, 32'd1);
    tick(); mem_rvalid = 0; mem_gnt = 1; settle();
    check("sp_addr_hold", {31'd0, mem_req}, 32'd1);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99; settle();
    check("sp_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("sp_rdata", if_rdata, 32'h99);
    tick(); clear_inputs();

    // Reset for one cycle while in RESP
    dm_req = 1; dm_addr = 32'h300;
    tick(); dm_req = 0; mem_gnt = 1;
    tick(); mem_gnt = 0; rst_n = 0; settle();
    check("mr_rst_busy", {31'd0, busy}, 32'd0);
    check("mr_rst_dmrv", {31'd0, dm_rvalid}, 32'd0);
    tick(); rst_n = 1; settle();
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_mreq", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1; mem_rdata = 32'h55; settle();
    check("mr_late_dmrv", {31'd0, dm_rvalid}, 32'd0);
    check("mr_late_dmrd", dm_rdata, 32'd0);
    tick(); clear_inputs(); settle();
    check("mr_still_idle", {31'd0, busy}, 32'd0);

    // Memory grants but never responds
    if_req = 1; if_addr = 32'h40;
    tick(); if_req = 0; mem_gnt = 1; settle();   // cycle 1 after leaving IDLE
    check("to_c1_err", {31'd0, bus_err}, 32'd0);
    tick(); mem_gnt = 0;
    for (int c = 2; c <= 7; c++) begin
      settle();
      check("to_pre_rv", {31'd0, if_rvalid}, 32'd0);
      check("to_pre_err", {31'd0, bus_err}, 32'd0);
      tick();
    end
    settle();                                       // cycle 8
`ifdef MEM_ARB_TIMEOUT_EN
    check("to_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("to_rdata", if_rdata, 32'hDEAD_BEEF);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_dm_rv", {31'd0, dm_rvalid}, 32'd0);
    tick(); settle();
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_err_clear", {31'd0, bus_err}, 32'd0);
`else
    check("to_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("to_bus_err", {31'd0, bus_err}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd1);
    repeat (20) tick();
    settle();
    check("to_busy_late", {31'd0, busy}, 32'd1);
    check("to_err_late", {31'd0, bus_err}, 32'd0);
    rst_n = 0;
    tick(); rst_n = 1; settle();
    check("to_rst_idle", {31'd0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
